// File: rtl/vga_fb_sched.sv
// vga_fb_sched: arbiter for the single-port 256x240 framebuffer RAM.
// Line fetches for the VGA line buffer have absolute priority. PPU pixel
// writes are queued in a small FIFO and drained while no fetch is running.
// Each NES source line L is fetched once, ahead of VGA lines 2L and 2L+1.
//
// Ports:
//   pck, rst          pixel clock, synchronous active-high reset
//   hcnt, vcnt        640x480 timing counters (800x525 frame)
//   ppu_we/addr/data  PPU pixel write, addr = {y, x}
//   ppu_ready         FIFO has room for a write
//   ppu_ovf           sticky flag: a write was dropped
//   fb_addr/we/wdata  registered RAM request
//   fb_rdata          RAM read data, one cycle after the address
//   lb_we/addr/wdata  line buffer write port, addr = {bank, x}
//   lb_rd_bank        line buffer bank the display currently reads
//   fetch_busy        a line fetch is in progress
module vga_fb_sched #(
  parameter logic [9:0] FETCH_START = 10'd0,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         VMAX        = 525,
  parameter int         VACT        = 480
) (
  input  logic        pck,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic        ppu_we,
  input  logic [15:0] ppu_addr,
  input  logic [5:0]  ppu_data,
  output logic        ppu_ready,
  output logic        ppu_ovf,
  output logic [15:0] fb_addr,
  output logic        fb_we,
  output logic [5:0]  fb_wdata,
  input  logic [5:0]  fb_rdata,
  output logic        lb_we,
  output logic [8:0]  lb_addr,
  output logic [5:0]  lb_wdata,
  output logic        lb_rd_bank,
  output logic        fetch_busy
);

  localparam int         PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CW     = PW + 1;
  localparam logic [9:0] VLAST  = 10'(VMAX - 1);
  localparam logic [9:0] VACT_V = 10'(VACT);

  typedef enum logic [1:0] {IDLE, FETCH, TAIL} state_t;

  state_t        state;
  logic [7:0]    line;
  logic [7:0]    x;
  logic          rd_issued;
  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [5:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [9:0]    vnext;
  logic          trig;
  logic [7:0]    trig_line;
  logic          push;
  logic          pop;

  // Decide whether this edge starts a fetch. The last frame line prefetches
  // source line 0; otherwise every odd VGA line prefetches the source line
  // shown on the next two VGA lines.
  always_comb begin
    vnext     = vcnt + 10'd1;
    trig      = 1'b0;
    trig_line = 8'd0;
    if (state == IDLE && hcnt == FETCH_START) begin
      if (vcnt == VLAST) begin
        trig = 1'b1;
      end else if (vnext < VACT_V && vcnt[0]) begin
        trig      = 1'b1;
        trig_line = vnext[8:1];
      end
    end
  end

  assign ppu_ready  = (count < CW'(FIFO_DEPTH));
  assign push       = ppu_we && ppu_ready;
  // A queued write may use the RAM only on an idle edge that does not start a fetch.
  assign pop        = (state == IDLE) && !trig && (count != '0);
  assign lb_wdata   = fb_rdata;
  assign lb_rd_bank = vcnt[1];
  assign fetch_busy = (state != IDLE);

  // FIFO storage; contents are meaningless once count is cleared, so no reset.
  always_ff @(posedge pck) begin
    if (push && !rst) begin
      fifo_addr[wptr] <= ppu_addr;
      fifo_data[wptr] <= ppu_data;
    end
  end

  // Fetch sequencer, write drain, and the line buffer write pipeline.
  // lb_* trails the read issue by one cycle so that fb_rdata lines up.
  always_ff @(posedge pck) begin
    if (rst) begin
      state     <= IDLE;
      line      <= 8'd0;
      x         <= 8'd0;
      rd_issued <= 1'b0;
      fb_addr   <= 16'd0;
      fb_we     <= 1'b0;
      fb_wdata  <= 6'd0;
      lb_we     <= 1'b0;
      lb_addr   <= 9'd0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ppu_ovf   <= 1'b0;
    end else begin
      fb_we     <= 1'b0;
      rd_issued <= 1'b0;
      lb_we     <= rd_issued;
      if (rd_issued) begin
        lb_addr <= {line[0], fb_addr[7:0]};
      end

      case (state)
        IDLE: begin
          if (trig) begin
            state <= FETCH;
            line  <= trig_line;
            x     <= 8'd0;
          end else if (pop) begin
            fb_we    <= 1'b1;
            fb_addr  <= fifo_addr[rptr];
            fb_wdata <= fifo_data[rptr];
            rptr     <= rptr + PW'(1);
          end
        end
        FETCH: begin
          fb_addr   <= {line, x};
          rd_issued <= 1'b1;
          x         <= x + 8'd1;
          if (x == 8'hFF) begin
            state <= TAIL;
          end
        end
        TAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      // A write offered while full is lost even if a pop frees a slot on this edge.
      if (ppu_we && !ppu_ready) begin
        ppu_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_sched.sv
// tb_vga_fb_sched: randomized scoreboard bench for vga_fb_sched.
// A behavioural model tracks the write queue, the fetch window (cycles since
// the trigger) and the expected RAM and line buffer traffic. A monitor on the
// falling edge compares the DUT outputs against it.
module tb_vga_fb_sched;

  logic        pck = 1'b0;
  logic        rst;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        ppu_we;
  logic [15:0] ppu_addr;
  logic [5:0]  ppu_data;
  logic        ppu_ready;
  logic        ppu_ovf;
  logic [15:0] fb_addr;
  logic        fb_we;
  logic [5:0]  fb_wdata;
  logic [5:0]  fb_rdata;
  logic        lb_we;
  logic [8:0]  lb_addr;
  logic [5:0]  lb_wdata;
  logic        lb_rd_bank;
  logic        fetch_busy;

  vga_fb_sched dut (
    .pck(pck), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_data(ppu_data),
    .ppu_ready(ppu_ready), .ppu_ovf(ppu_ovf),
    .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_rd_bank(lb_rd_bank), .fetch_busy(fetch_busy)
  );

  always #5 pck = ~pck;

  // Framebuffer RAM with one cycle of read latency.
  logic [5:0] ram [65536];
  always @(posedge pck) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    fb_rdata <= ram[fb_addr];
  end

  typedef struct {
    logic [15:0] addr;
    logic [5:0]  data;
  } wr_t;
  typedef struct {
    logic [8:0]  lb;
    logic [15:0] src;
  } lb_t;

  wr_t m_fifo[$];
  wr_t exp_wr[$];
  lb_t exp_lb[$];
  int  m_since = 1000;
  bit  m_ovf = 1'b0;
  bit  m_fbwe_exp = 1'b0;
  bit  m_after_rst = 1'b0;
  logic [7:0] m_line = 8'd0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model. A fetch keeps the RAM for the trigger edge plus 257
  // further edges; lines and banks follow the VGA-to-NES line doubling.
  always @(posedge pck) begin
    bit idle, full_before, trig;
    int lnum;
    lb_t e;
    if (rst) begin
      m_fifo.delete();
      exp_wr.delete();
      exp_lb.delete();
      m_since     = 1000;
      m_ovf       = 1'b0;
      m_fbwe_exp  = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      idle        = (m_since >= 257);
      full_before = (m_fifo.size() >= 4);
      trig        = 1'b0;
      lnum        = 0;
      if (idle && hcnt == 10'd0) begin
        if (vcnt == 10'd524) begin
          trig = 1'b1;
          lnum = 0;
        end else if (int'(vcnt) + 1 < 480 && (vcnt % 2) == 1) begin
          trig = 1'b1;
          lnum = (int'(vcnt) + 1) / 2;
        end
      end
      m_fbwe_exp = 1'b0;
      if (trig) begin
        m_since = 0;
        m_line  = 8'(lnum);
        for (int xi = 0; xi < 256; xi++) begin
          e.lb  = {lnum[0], 8'(xi)};
          e.src = {8'(lnum), 8'(xi)};
          exp_lb.push_back(e);
        end
      end else begin
        if (m_since < 1000) m_since++;
        if (idle && m_fifo.size() > 0) begin
          exp_wr.push_back(m_fifo.pop_front());
          m_fbwe_exp = 1'b1;
        end
      end
      if (ppu_we) begin
        if (!full_before) m_fifo.push_back('{addr: ppu_addr, data: ppu_data});
        else m_ovf = 1'b1;
      end
      m_after_rst = 1'b0;
    end
  end

  // Monitor: compares DUT outputs with the model between clock edges.
  always @(negedge pck) begin
    wr_t w;
    lb_t l;
    if (m_after_rst) begin
      checkOutput("rst_ready", ppu_ready, 1);
      checkOutput("rst_ovf", ppu_ovf, 0);
      checkOutput("rst_fb_we", fb_we, 0);
      checkOutput("rst_fb_addr", fb_addr, 0);
      checkOutput("rst_fb_wdata", fb_wdata, 0);
      checkOutput("rst_lb_we", lb_we, 0);
      checkOutput("rst_lb_addr", lb_addr, 0);
      checkOutput("rst_busy", fetch_busy, 0);
    end else begin
      checkOutput("ready", ppu_ready, m_fifo.size() < 4);
      checkOutput("ovf", ppu_ovf, m_ovf);
      checkOutput("busy", fetch_busy, m_since <= 256);
      checkOutput("fb_we", fb_we, m_fbwe_exp);
      checkOutput("lb_we", lb_we, m_since >= 2 && m_since <= 257);
      checkOutput("rd_bank", lb_rd_bank, vcnt[1]);
      if (m_since >= 1 && m_since <= 256)
        checkOutput("fetch_addr", fb_addr, {m_line, 8'(m_since - 1)});
      if (fb_we) begin
        if (exp_wr.size() == 0) begin
          checkOutput("wr_unexpected", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          checkOutput("wr_addr", fb_addr, w.addr);
          checkOutput("wr_data", fb_wdata, w.data);
        end
      end
      if (lb_we) begin
        if (exp_lb.size() == 0) begin
          checkOutput("lb_unexpected", 1, 0);
        end else begin
          l = exp_lb.pop_front();
          checkOutput("lb_addr", lb_addr, l.lb);
          checkOutput("lb_data", lb_wdata, ram[l.src]);
        end
      end
    end
  end

  task automatic applyStimulus(input bit we, input logic [15:0] a, input logic [5:0] d,
                               input logic [9:0] h, input logic [9:0] v);
    @(negedge pck);
    ppu_we   = we;
    ppu_addr = a;
    ppu_data = d;
    hcnt     = h;
    vcnt     = v;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 6'h0, 10'd1, 10'd100);
  endtask

  function automatic logic [15:0] rand_addr();
    return {8'($urandom_range(0, 239)), 8'($urandom)};
  endfunction

  initial begin
    logic [9:0] h, v;
    rst      = 1'b1;
    ppu_we   = 1'b0;
    ppu_addr = 16'h0;
    ppu_data = 6'h0;
    hcnt     = 10'd1;
    vcnt     = 10'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 6'($urandom);

    // Reset held for three cycles with random write traffic.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom), rand_addr(), 6'($urandom), 10'd1, 10'd100);
    @(negedge pck);
    rst = 1'b0;
    idle_cycles(3);

    // Single idle write: visible on the RAM port after the second edge.
    applyStimulus(1'b1, 16'h1234, 6'h2A, 10'd1, 10'd100);
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd1, 10'd100);
    @(posedge pck);
    #1;
    checkOutput("idle_wr_we", fb_we, 1);
    checkOutput("idle_wr_addr", fb_addr, 16'h1234);
    checkOutput("idle_wr_data", fb_wdata, 6'h2A);
    idle_cycles(4);

    // Line 0 fetch from the last frame line.
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd524);
    idle_cycles(270);

    // Line 5 fetch with three writes arriving mid-fetch.
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd9);
    idle_cycles(50);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rand_addr(), 6'($urandom), 10'd1, 10'd100);
    idle_cycles(230);

    // Lines that must not trigger.
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd10);
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd479);
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd480);
    idle_cycles(5);

    // Overflow during a fetch, then reset around x=100.
    applyStimulus(1'b0, 16'h0, 6'h0, 10'd0, 10'd1);
    idle_cycles(10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, rand_addr(), 6'($urandom), 10'd1, 10'd100);
    idle_cycles(85);
    @(negedge pck);
    rst = 1'b1;
    @(negedge pck);
    rst = 1'b0;
    idle_cycles(10);

    // Free-running timing with random writes across the frame wrap.
    h = 10'd0;
    v = 10'd523;
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), rand_addr(), 6'($urandom), h, v);
      if (h == 10'd799) begin
        h = 10'd0;
        v = (v == 10'd524) ? 10'd0 : v + 10'd1;
      end else begin
        h = h + 10'd1;
      end
    end

    // Drain everything and confirm nothing expected was left behind.
    idle_cycles(300);
    checkOutput("wr_queue_drained", exp_wr.size(), 0);
    checkOutput("lb_queue_drained", exp_lb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
